// File: rtl/mpi_tx_arb_pkg.sv
// Shared types and widths for the MPI egress arbiter.
// Optional statistics are enabled by defining MPI_TX_ARB_STATS_EN.
package mpi_tx_arb_pkg;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int CNT_W  = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mpi_tx_arbiter_rr_priority_select.sv
// Round-robin priority search: first requester after last_grant, cyclically.
// Ports: req (request vector), last_grant (in); grant (index), any_req (out).
module rr_priority_select
    import mpi_tx_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last_grant,
    output logic [PORT_W-1:0]    grant,
    output logic                 any_req
);

    always_comb begin
        int idx;
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        // Offsets 1..NUM_PORTS: the previous winner is checked last.
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = (int'(last_grant) + i) % NUM_PORTS;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                grant   = PORT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mpi_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one 64-bit MPI egress stream.
// Ports: clk, rst (sync, active-high); stream_in_* per-port AXI-S ingress;
// stream_out_* egress; grant_port, busy status. With MPI_TX_ARB_STATS_EN:
// pkt_count (per-port completed packets) and stall_count (egress stalls).
module mpi_tx_arbiter
    import mpi_tx_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*DATA_W-1:0] stream_in_DATA,
    input  logic [NUM_PORTS*KEEP_W-1:0] stream_in_KEEP,
    input  logic [NUM_PORTS-1:0]        stream_in_LAST,
    input  logic [NUM_PORTS-1:0]        stream_in_VALID,
    output logic [NUM_PORTS-1:0]        stream_in_READY,
    output logic [DATA_W-1:0]           stream_out_DATA,
    output logic [KEEP_W-1:0]           stream_out_KEEP,
    output logic                        stream_out_LAST,
    output logic                        stream_out_VALID,
    input  logic                        stream_out_READY,
    output logic [PORT_W-1:0]           grant_port,
    output logic                        busy
`ifdef MPI_TX_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]            stall_count
`endif
);

    arb_state_t        state;
    logic [PORT_W-1:0] last_grant;
    logic [PORT_W-1:0] sel;
    logic              any_req;
    logic              beat_ok;
    logic              pkt_done;

    rr_priority_select #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_sel (
        .req        (stream_in_VALID),
        .last_grant (last_grant),
        .grant      (sel),
        .any_req    (any_req)
    );

    assign busy = (state == BUSY);

    // Pure mux while a packet is granted; everything quiet in IDLE.
    always_comb begin
        stream_out_DATA  = '0;
        stream_out_KEEP  = '0;
        stream_out_LAST  = 1'b0;
        stream_out_VALID = 1'b0;
        stream_in_READY  = '0;
        if (state == BUSY) begin
            stream_out_DATA  = stream_in_DATA[int'(grant_port)*DATA_W +: DATA_W];
            stream_out_KEEP  = stream_in_KEEP[int'(grant_port)*KEEP_W +: KEEP_W];
            stream_out_LAST  = stream_in_LAST[grant_port];
            stream_out_VALID = stream_in_VALID[grant_port];
            stream_in_READY[grant_port] = stream_out_READY;
        end
    end

    assign beat_ok  = stream_out_VALID && stream_out_READY;
    assign pkt_done = beat_ok && stream_out_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= PORT_W'(NUM_PORTS - 1);
            grant_port <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_port <= sel;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // Grant held until LAST is taken; a VALID gap just waits.
                    if (pkt_done) begin
                        last_grant <= grant_port;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MPI_TX_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            if (pkt_done) begin
                pkt_count[int'(grant_port)*CNT_W +: CNT_W] <=
                    pkt_count[int'(grant_port)*CNT_W +: CNT_W] + CNT_W'(1);
            end
            if (busy && stream_out_VALID && !stream_out_READY) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mpi_tx_arbiter.sv
// Directed self-checking bench for mpi_tx_arbiter (NUM_PORTS = 4).
// Statistics checks are compiled in when MPI_TX_ARB_STATS_EN is defined.
module tb_mpi_tx_arbiter;

    localparam int NP = 4;

    logic            clk;
    logic            rst;
    logic [NP*64-1:0] in_data;
    logic [NP*8-1:0] in_keep;
    logic [NP-1:0]   in_last;
    logic [NP-1:0]   in_valid;
    logic [NP-1:0]   in_ready;
    logic [63:0]     out_data;
    logic [7:0]      out_keep;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      grant_port;
    logic            busy;
`ifdef MPI_TX_ARB_STATS_EN
    logic [NP*32-1:0] pkt_count;
    logic [31:0]     stall_count;
`endif

    mpi_tx_arbiter #(.NUM_PORTS(NP)) dut (
        .clk              (clk),
        .rst              (rst),
        .stream_in_DATA   (in_data),
        .stream_in_KEEP   (in_keep),
        .stream_in_LAST   (in_last),
        .stream_in_VALID  (in_valid),
        .stream_in_READY  (in_ready),
        .stream_out_DATA  (out_data),
        .stream_out_KEEP  (out_keep),
        .stream_out_LAST  (out_last),
        .stream_out_VALID (out_valid),
        .stream_out_READY (out_ready),
        .grant_port       (grant_port),
        .busy             (busy)
`ifdef MPI_TX_ARB_STATS_EN
        ,
        .pkt_count        (pkt_count),
        .stall_count      (stall_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [72:0] srcq [NP][$];
    bit          hold [NP];
    bit          acc [NP];
    bit          rdy_pat [$];
    bit          busy_hist [0:2047];

    int          log_port [$];
    logic [63:0] log_data [$];
    logic [7:0]  log_keep [$];
    bit          log_last [$];
    int          log_cyc [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Source driver: pop accepted beats, present queue heads.
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++)
            if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        out_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
        for (int i = 0; i < NP; i++) begin
            if (srcq[i].size() > 0 && !hold[i]) begin
                in_valid[i] = 1'b1;
                {in_last[i], in_keep[i*8 +: 8], in_data[i*64 +: 64]} = srcq[i][0];
            end else begin
                in_valid[i] = 1'b0;
                in_last[i] = 1'b0;
                in_keep[i*8 +: 8] = '0;
                in_data[i*64 +: 64] = '0;
            end
        end
    end

    // Monitor at the falling edge, clear of the active edge.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NP; i++) acc[i] = in_valid[i] && in_ready[i];
        if (cyc < 2048) busy_hist[cyc] = busy;
        if (out_valid && out_ready) begin
            log_port.push_back(int'(grant_port));
            log_data.push_back(out_data);
            log_keep.push_back(out_keep);
            log_last.push_back(out_last);
            log_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] mk(input int p, input int pk, input int b);
        return {8'(p), 8'(pk), 48'(b)};
    endfunction

    task automatic send(input int p, input int pk, input int nb);
        for (int b = 0; b < nb; b++)
            srcq[p].push_back({(b == nb - 1), (b == nb - 1) ? 8'h0f : 8'hff, mk(p, pk, b)});
    endtask

    task automatic clear_log();
        log_port.delete();
        log_data.delete();
        log_keep.delete();
        log_last.delete();
        log_cyc.delete();
    endtask

    function automatic bit q_empty();
        for (int i = 0; i < NP; i++) if (srcq[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        step();
        while ((!q_empty() || busy) && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL %s_drain got=busy exp=idle within %0d cycles", name, budget);
        end
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NP; i++) begin
            srcq[i].delete();
            hold[i] = 1'b0;
        end
        rdy_pat.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0 || grant_port !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b grant=%0d exp busy=0 grant=0", busy, grant_port);
        end
        checks++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs got ready=%b valid=%b last=%b exp 0000/0/0", in_ready, out_valid, out_last);
        end
        checks++;
        if (out_data !== 64'd0 || out_keep !== 8'd0) begin
            errors++;
            $display("FAIL reset_data got data=%h keep=%h exp 0/0", out_data, out_keep);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_port();
        int n;
        clear_log();
        n = cyc;
        for (int b = 0; b < 12; b++) srcq[1].push_back({(b == 11), 8'hff, 64'd13});
        step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 64'd0 ||
            out_keep !== 8'd0 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL sp_idle got busy=%b valid=%b data=%h keep=%h ready=%b exp 0/0/0/0/0000",
                     busy, out_valid, out_data, out_keep, in_ready);
        end
        step();
        checks++;
        if (busy !== 1'b1 || grant_port !== 2'd1 || out_valid !== 1'b1 ||
            out_data !== 64'd13 || in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL sp_grant got busy=%b grant=%0d valid=%b data=%h ready=%b exp 1/1/1/13/0010",
                     busy, grant_port, out_valid, out_data, in_ready);
        end
        wait_idle(40, "sp");
        checks++;
        if (log_data.size() !== 12) begin
            errors++;
            $display("FAIL sp_count got=%0d exp=12", log_data.size());
        end
        for (int j = 0; j < 12 && j < log_data.size(); j++) begin
            checks++;
            if (log_port[j] !== 1 || log_data[j] !== 64'd13 || log_keep[j] !== 8'hff ||
                log_last[j] !== (j == 11) || log_cyc[j] !== n + 2 + j) begin
                errors++;
                $display("FAIL sp_beat%0d got port=%0d data=%h keep=%h last=%b cyc=%0d exp 1/13/ff/%b/%0d",
                         j, log_port[j], log_data[j], log_keep[j], log_last[j], log_cyc[j],
                         (j == 11), n + 2 + j);
            end
        end
        checks++;
        if (busy_hist[n + 14] !== 1'b0) begin
            errors++;
            $display("FAIL sp_gap got busy=%b exp=0", busy_hist[n + 14]);
        end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        clear_log();
        n = cyc;
        for (int p = 0; p < NP; p++) send(p, p, 3);
        wait_idle(100, "rr");
        checks++;
        if (log_data.size() !== 12) begin
            errors++;
            $display("FAIL rr_count got=%0d exp=12", log_data.size());
        end
        for (int j = 0; j < 12 && j < log_data.size(); j++) begin
            int k;
            int b;
            int ec;
            k = j / 3;
            b = j % 3;
            ec = n + 2 + 4 * k + b;
            checks++;
            if (log_port[j] !== k || log_data[j] !== mk(k, k, b) ||
                log_keep[j] !== ((b == 2) ? 8'h0f : 8'hff) ||
                log_last[j] !== (b == 2) || log_cyc[j] !== ec) begin
                errors++;
                $display("FAIL rr_beat%0d got port=%0d data=%h last=%b cyc=%0d exp port=%0d data=%h last=%b cyc=%0d",
                         j, log_port[j], log_data[j], log_last[j], log_cyc[j],
                         k, mk(k, k, b), (b == 2), ec);
            end
        end
        checks++;
        if (busy_hist[n + 5] !== 1'b0 || busy_hist[n + 9] !== 1'b0) begin
            errors++;
            $display("FAIL rr_gap got busy=%b%b exp=00", busy_hist[n + 5], busy_hist[n + 9]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int tp [4] = '{2, 0, 2, 2};
        int tk [4] = '{0, 0, 1, 2};
        int tc [4] = '{2, 5, 8, 11};
        clear_log();
        n = cyc;
        send(2, 0, 2);
        send(2, 1, 2);
        send(2, 2, 2);
        step();
        step();
        send(0, 0, 2);
        wait_idle(60, "b2b");
        checks++;
        if (log_data.size() !== 8) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=8", log_data.size());
        end
        for (int j = 0; j < 8 && j < log_data.size(); j++) begin
            int q;
            int b;
            q = j / 2;
            b = j % 2;
            checks++;
            if (log_port[j] !== tp[q] || log_data[j] !== mk(tp[q], tk[q], b) ||
                log_last[j] !== (b == 1) || log_cyc[j] !== n + tc[q] + b) begin
                errors++;
                $display("FAIL b2b_beat%0d got port=%0d data=%h cyc=%0d exp port=%0d data=%h cyc=%0d",
                         j, log_port[j], log_data[j], log_cyc[j],
                         tp[q], mk(tp[q], tk[q], b), n + tc[q] + b);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [3:0] er [6] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010};
        int ec [4] = '{2, 5, 6, 7};
`ifdef MPI_TX_ARB_STATS_EN
        logic [31:0] s0;
        s0 = stall_count;
`endif
        clear_log();
        n = cyc;
        send(1, 5, 4);
        rdy_pat.push_back(1'b1);
        rdy_pat.push_back(1'b1);
        rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b0);
        step();
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (in_ready !== er[k] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_ready%0d got ready=%b valid=%b exp ready=%b valid=1",
                         k, in_ready, out_valid, er[k]);
            end
        end
        wait_idle(40, "bp");
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (b >= log_data.size()) begin
                errors++;
                $display("FAIL bp_beat%0d got=missing exp=present", b);
            end else if (log_port[b] !== 1 || log_data[b] !== mk(1, 5, b) ||
                         log_cyc[b] !== n + ec[b]) begin
                errors++;
                $display("FAIL bp_beat%0d got port=%0d data=%h cyc=%0d exp port=1 data=%h cyc=%0d",
                         b, log_port[b], log_data[b], log_cyc[b], mk(1, 5, b), n + ec[b]);
            end
        end
`ifdef MPI_TX_ARB_STATS_EN
        checks++;
        if (stall_count - s0 !== 32'd2) begin
            errors++;
            $display("FAIL bp_stall got=%0d exp=2", stall_count - s0);
        end
`endif
    endtask

    task automatic test_valid_drop();
        int n;
        int tp [4] = '{3, 3, 3, 0};
        int tk [4] = '{7, 7, 7, 8};
        int tb [4] = '{0, 1, 2, 0};
        int tc [4] = '{2, 5, 6, 8};
        bit tl [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        clear_log();
        n = cyc;
        send(3, 7, 3);
        step();
        step();
        hold[3] = 1'b1;
        send(0, 8, 1);
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (busy !== 1'b1 || grant_port !== 2'd3 || out_valid !== 1'b0 ||
                in_ready !== 4'b1000) begin
                errors++;
                $display("FAIL vd_hold%0d got busy=%b grant=%0d valid=%b ready=%b exp 1/3/0/1000",
                         k, busy, grant_port, out_valid, in_ready);
            end
        end
        hold[3] = 1'b0;
        wait_idle(40, "vd");
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (j >= log_data.size()) begin
                errors++;
                $display("FAIL vd_beat%0d got=missing exp=present", j);
            end else if (log_port[j] !== tp[j] || log_data[j] !== mk(tp[j], tk[j], tb[j]) ||
                         log_last[j] !== tl[j] || log_cyc[j] !== n + tc[j]) begin
                errors++;
                $display("FAIL vd_beat%0d got port=%0d data=%h cyc=%0d exp port=%0d data=%h cyc=%0d",
                         j, log_port[j], log_data[j], log_cyc[j],
                         tp[j], mk(tp[j], tk[j], tb[j]), n + tc[j]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int tp [3] = '{0, 2, 3};
        int tk [3] = '{12, 10, 11};
        int tc [3] = '{6, 8, 10};
        n = cyc;
        send(2, 9, 5);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rm_abort got valid=%b ready=%b busy=%b exp 0/0000/0",
                     out_valid, in_ready, busy);
        end
        clear_log();
        srcq[2].delete();
        send(2, 10, 1);
        send(3, 11, 1);
        send(0, 12, 1);
        step();
        rst = 1'b0;
        wait_idle(40, "rm");
        checks++;
        if (log_data.size() !== 3) begin
            errors++;
            $display("FAIL rm_count got=%0d exp=3", log_data.size());
        end
        for (int j = 0; j < 3 && j < log_data.size(); j++) begin
            checks++;
            if (log_port[j] !== tp[j] || log_data[j] !== mk(tp[j], tk[j], 0) ||
                log_keep[j] !== 8'h0f || log_last[j] !== 1'b1 || log_cyc[j] !== n + tc[j]) begin
                errors++;
                $display("FAIL rm_beat%0d got port=%0d data=%h cyc=%0d exp port=%0d data=%h cyc=%0d",
                         j, log_port[j], log_data[j], log_cyc[j],
                         tp[j], mk(tp[j], tk[j], 0), n + tc[j]);
            end
        end
    endtask

`ifdef MPI_TX_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++;
        if (pkt_count !== '0 || stall_count !== 32'd0) begin
            errors++;
            $display("FAIL st_clear got pkt=%h stall=%0d exp 0/0", pkt_count, stall_count);
        end
        send(3, 1, 1);
        send(3, 2, 2);
        send(3, 3, 1);
        send(3, 4, 3);
        send(3, 5, 1);
        wait_idle(80, "st");
        checks++;
        if (pkt_count[127:96] !== 32'd5) begin
            errors++;
            $display("FAIL st_port3 got=%0d exp=5", pkt_count[127:96]);
        end
        checks++;
        if (pkt_count[95:0] !== 96'd0) begin
            errors++;
            $display("FAIL st_others got=%h exp=0", pkt_count[95:0]);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_data = '0;
        in_keep = '0;
        in_last = '0;
        in_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < NP; i++) begin
            hold[i] = 1'b0;
            acc[i] = 1'b0;
        end
        step();
        step();
        step();
        test_reset();
        test_single_port();
        test_round_robin();
        test_back_to_back();
        test_backpressure();
        test_valid_drop();
        test_reset_mid();
`ifdef MPI_TX_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpi_tx_arbiter.md
# mpi_tx_arbiter

Packet-granular round-robin arbiter that shares the single 64-bit MPI/Ethernet egress stream between `NUM_PORTS` MPI sender kernels. Each requester presents complete MPI packets: a header beat (dst_rank, src_rank, size, MAC/IP fields), then payload, ending on LAST. The arbiter grants one port at a time and holds the grant until that packet's LAST beat is accepted, so packets are never interleaved. It sits between the kernel-side MPI senders and the Ethernet TX path.

## Interface
- `NUM_PORTS`, default 4: number of requesting streams, 2..16.
- `PORT_W`, default `$clog2(NUM_PORTS)`: grant index width.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stream_in_DATA`  in  NUM_PORTS*64  per-port data; port i in bits [64i+63:64i].
- `stream_in_KEEP`  in  NUM_PORTS*8  per-port byte enables.
- `stream_in_LAST`  in  NUM_PORTS  per-port end of packet.
- `stream_in_VALID`  in  NUM_PORTS  per-port beat valid.
- `stream_in_READY`  out  NUM_PORTS  per-port ready.
- `stream_out_DATA`  out  64  egress data.
- `stream_out_KEEP`  out  8  egress byte enables.
- `stream_out_LAST`  out  1  egress end of packet.
- `stream_out_VALID`  out  1  egress valid.
- `stream_out_READY`  in  1  egress ready.
- `grant_port`  out  PORT_W  currently granted port (valid in BUSY).
- `busy`  out  1  high while a packet is being forwarded.

## Operation
- FSM states: IDLE, BUSY.
- IDLE: if any `stream_in_VALID` set, select first valid port searching from `last_grant+1` cyclically; register it into `grant_port`, go BUSY. No beat is forwarded in IDLE.
- BUSY: `stream_out_*` = `stream_in_*[grant_port]`; `stream_in_READY[grant_port]` = `stream_out_READY`; all other READY bits 0.
- Beat accepted = `stream_out_VALID && stream_out_READY`. On accepted beat with LAST: `last_grant <= grant_port`, go IDLE.
- Granted port dropping VALID mid-packet: stay BUSY, output VALID low, no timeout, no regrant.
- Headers are not parsed or modified; payload passes unchanged, including KEEP.

## Timing
- Reset values: state IDLE, `last_grant` = NUM_PORTS-1 (port 0 wins first), `grant_port` 0, `busy` 0, `stream_in_READY` all 0, `stream_out_VALID` 0, `stream_out_LAST` 0, DATA/KEEP 0 in IDLE.
- Grant latency: requester VALID in cycle t (IDLE) -> first beat visible on egress in cycle t+1.
- Inter-packet gap: exactly one IDLE cycle after every accepted LAST, even if the same or another port is waiting.
- Data path in BUSY is combinational (mux only); no added latency per beat; egress backpressure propagates to the granted port same cycle.
- Single-beat packet (header with LAST): BUSY for one accepted cycle, then IDLE.
- Reset mid-packet: next cycle IDLE, all READY low, egress VALID low; partial packet is abandoned, no fix-up.
- Simultaneous requests: strictly round-robin; a port cannot win twice while another valid port is waiting.

## Configuration
- `MPI_TX_ARB_STATS_EN` defined: adds output `pkt_count` (NUM_PORTS*32, per-port packets completed, incremented on accepted LAST, wraps at 2^32) and `stall_count` (32, cycles in BUSY with egress VALID high and READY low, wraps). Both clear on `rst`.
- Undefined: those ports and counters do not exist; behaviour otherwise identical.

## Structure
- Package `mpi_tx_arb_pkg`: `DATA_W`=64, `KEEP_W`=8, state enum `arb_state_t` {IDLE, BUSY}, `CNT_W`=32.
- One sub-module `rr_priority_select`: combinational, inputs request vector and last_grant, outputs grant index and `any_req`.

## Test plan
- Single port 1 sends header + 11 beats of data 64'd13, KEEP 8'hff, LAST on beat 12 -> egress shows 12 identical beats, `grant_port`=1, then one IDLE cycle, `busy` 0.
- Ports 0,1,2,3 all valid after reset, 3-beat packets each -> egress order 0,1,2,3, one-cycle gap between each, no interleaving.
- Port 2 sends 3 back-to-back packets while port 0 requests after the first -> order 2,0,2,2.
- Egress READY toggles 1,0,0,1 during a 4-beat packet -> granted port's READY mirrors it, all beats delivered in order, `stall_count` +2 (with STATS_EN).
- `rst` asserted on beat 2 of a 5-beat packet -> next cycle VALID 0, all READY 0; after release port 0 wins first.
- With `MPI_TX_ARB_STATS_EN`: 5 packets from port 3 -> `pkt_count[3]`=5, others 0.
